ysyx_220053_fetch_unit: RTL and testbench
=========================================

YSYX_220053_FETCH_UNIT -- requirements
Module: ysyx_220053_fetch_unit

Interface
REQ-001 Parameter: RESET_PC, default 64'h0000_0000_8000_0000, first fetch address after reset.
REQ-002 Parameter: BUF_DEPTH, default 2, instruction buffer entries (power of two, >=2).
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 imem_req_valid  output  1  fetch request valid.
REQ-006 imem_req_ready  input  1  memory accepts request.
REQ-007 imem_req_addr  output  64  fetch address, word aligned.
REQ-008 imem_resp_valid  input  1  instruction word returned (one per accepted request, in order).
REQ-009 imem_resp_data  input  32  instruction word.
REQ-010 redirect_valid  input  1  branch/jump redirect pulse from execute.
REQ-011 redirect_pc  input  64  redirect target.
REQ-012 halt  input  1  trap (ebreak) stop request.
REQ-013 instr_valid  output  1  buffer head valid to decoder.
REQ-014 instr_ready  input  1  decoder consumes head.
REQ-015 instr_o  output  32  head instruction word.
REQ-016 pc_o  output  64  head instruction PC.
REQ-017 misalign  output  1  one-cycle pulse: redirect_pc[1:0] != 0.

Function
REQ-018 FSM states IDLE, REQ, WAIT, HALT; at most one request outstanding.
REQ-019 IDLE -> REQ when buffer count < BUF_DEPTH; otherwise stays IDLE.
REQ-020 REQ: imem_req_valid=1, imem_req_addr=fetch_pc; on imem_req_ready -> WAIT; valid and addr held stable until accepted.
REQ-021 WAIT: on imem_resp_valid, non-stale response pushes {fetch_pc, data}, fetch_pc += 4 (64-bit wrap); -> REQ if post-push count < BUF_DEPTH, else IDLE.
REQ-022 Requests issue only with a free slot, so a push never meets a full buffer.
REQ-023 instr_valid = (count != 0); head pops on instr_valid & instr_ready; simultaneous push and pop leaves count unchanged.
REQ-024 Redirect (any state except HALT): buffer flushed (count=0 next cycle), fetch_pc <= {redirect_pc[63:2],2'b00}, misalign pulses if low bits nonzero; redirect overrides same-cycle push and pop.
REQ-025 Redirect with request in flight (WAIT, or REQ accepted same cycle): stale flag set; matching response discarded, stale cleared, then -> REQ.
REQ-026 Redirect in REQ without acceptance: old request completes as stale; new address issued afterwards.
REQ-027 halt in IDLE/REQ(unaccepted) -> HALT next cycle; in WAIT, response consumed normally, then HALT; halt and redirect same cycle: halt wins, buffer flushed.
REQ-028 HALT: no requests, buffer still drains to decoder, exits only via reset.

Reset
REQ-029 rst_n low: state IDLE, fetch_pc=RESET_PC, count=0, stale=0, imem_req_valid=0, instr_valid=0, misalign=0, instr_o=0, pc_o=0.
REQ-030 Reset mid-transaction discards in-flight request; memory side tolerates a dropped response.

Structure
REQ-031 Package ysyx_220053_pkg holds FSM state enum, RESET_PC default, 32-bit NOP constant 32'h0000_0013.
REQ-032 Buffer is sub-module ysyx_220053_fetch_fifo (push, pop, flush, count, 96-bit entries).

Verification
REQ-033 Reset release, ready=1, resp next cycle -> addresses 8000_0000, 8000_0004, ...; instr_o/pc_o match in order.
REQ-034 instr_ready=0 -> exactly BUF_DEPTH words buffered, imem_req_valid low, state IDLE; ready=1 resumes.
REQ-035 Redirect to 8000_0100 during WAIT -> pending response dropped, next pc_o = 8000_0100, buffer empty one cycle.
REQ-036 Redirect to 8000_0102 -> misalign pulse, fetch at 8000_0100.
REQ-037 halt during WAIT -> response buffered, no further requests, buffer drains, only reset restarts at RESET_PC.
REQ-038 Async rst_n assert mid-REQ -> outputs zero immediately, no clock required.

Source files
------------

// File: rtl/ysyx_220053_pkg.sv
// Shared types and constants for the ysyx_220053 instruction fetch slice.
package ysyx_220053_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_HALT
  } fetch_state_e;

  localparam logic [63:0] RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam int unsigned ENTRY_W          = 96;

endpackage

// File: rtl/ysyx_220053_fetch_fifo.sv
// Instruction buffer holding {pc, instruction} entries; flush empties it in one cycle.
module ysyx_220053_fetch_fifo
  import ysyx_220053_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [ENTRY_W-1:0]       push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [ENTRY_W-1:0]       head_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_ONE = 1;
  localparam logic [AW-1:0] PTR_ONE = 1;

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [AW-1:0]      rd_ptr;
  logic [AW-1:0]      wr_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  // Empty buffer presents zeros so the decoder side reads clean after reset/flush.
  assign head_data = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/ysyx_220053_fetch_unit.sv
// Fetch unit: single-outstanding instruction memory requester feeding a small buffer.
module ysyx_220053_fetch_unit
  import ysyx_220053_pkg::*;
#(
  parameter logic [63:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  input  logic        halt,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_o,
  output logic [63:0] pc_o,
  output logic        misalign
);

  localparam int unsigned   CW      = $clog2(BUF_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);

  fetch_state_e       state_q, state_d;
  logic [63:0]        fetch_pc_q, fetch_pc_d;
  logic [63:0]        req_addr_q, req_addr_d;
  logic               stale_q, stale_d;
  logic               halt_pend_q, halt_pend_d;
  logic               misalign_q, misalign_d;
  logic               push, pop, flush, drop;
  logic               redir_take;
  logic [63:0]        redir_al, tgt;
  logic [CW-1:0]      count, post_cnt;
  logic [ENTRY_W-1:0] head;

  assign redir_al   = {redirect_pc[63:2], 2'b00};
  assign redir_take = redirect_valid && !halt && (state_q != ST_HALT);
  assign flush      = redirect_valid && (state_q != ST_HALT);
  assign tgt        = redir_take ? redir_al : fetch_pc_q;
  assign pop        = instr_valid && instr_ready;
  assign post_cnt   = count + CW'(1) - CW'(pop);

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    req_addr_d  = req_addr_q;
    stale_d     = stale_q;
    halt_pend_d = halt_pend_q;
    misalign_d  = 1'b0;
    push        = 1'b0;
    drop        = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (halt) begin
          state_d = ST_HALT;
        end else if (redir_take || (count < DEPTH_C)) begin
          state_d    = ST_REQ;
          req_addr_d = tgt;
        end
      end
      // req_addr_q is held while unaccepted; a redirect here marks that old request stale.
      ST_REQ: begin
        if (imem_req_ready) begin
          state_d = ST_WAIT;
          if (halt)  halt_pend_d = 1'b1;
          if (flush) stale_d     = 1'b1;
        end else if (halt) begin
          state_d = ST_HALT;
        end else if (redir_take) begin
          stale_d = 1'b1;
        end
      end
      ST_WAIT: begin
        if (halt) halt_pend_d = 1'b1;
        if (imem_resp_valid) begin
          drop    = stale_q || flush;
          push    = !drop;
          stale_d = 1'b0;
          if (push) fetch_pc_d = fetch_pc_q + 64'd4;
          if (halt || halt_pend_q) begin
            state_d = ST_HALT;
          end else if (drop || (post_cnt < DEPTH_C)) begin
            state_d    = ST_REQ;
            req_addr_d = drop ? tgt : fetch_pc_q + 64'd4;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (flush) begin
          stale_d = 1'b1;
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: state_d = ST_IDLE;
    endcase
    if (redir_take) begin
      fetch_pc_d = redir_al;
      misalign_d = |redirect_pc[1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      fetch_pc_q  <= RESET_PC;
      req_addr_q  <= RESET_PC;
      stale_q     <= 1'b0;
      halt_pend_q <= 1'b0;
      misalign_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      req_addr_q  <= req_addr_d;
      stale_q     <= stale_d;
      halt_pend_q <= halt_pend_d;
      misalign_q  <= misalign_d;
    end
  end

  ysyx_220053_fetch_fifo #(
    .DEPTH(BUF_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data ({fetch_pc_q, imem_resp_data}),
    .pop       (pop),
    .flush     (flush),
    .head_data (head),
    .count     (count)
  );

  assign imem_req_valid = (state_q == ST_REQ);
  assign imem_req_addr  = req_addr_q;
  assign instr_valid    = (count != '0);
  assign instr_o        = head[31:0];
  assign pc_o           = head[95:32];
  assign misalign       = misalign_q;

endmodule

// File: tb/tb_ysyx_220053_fetch_unit.sv
// Directed and randomized bench for the fetch unit against an in-order PC stream model.
module tb_ysyx_220053_fetch_unit;
  import ysyx_220053_pkg::*;

  localparam logic [63:0] RST_PC = 64'h0000_0000_8000_0000;
  localparam int unsigned DEPTH  = 2;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        halt;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_o;
  logic [63:0] pc_o;
  logic        misalign;

  ysyx_220053_fetch_unit #(
    .RESET_PC  (RST_PC),
    .BUF_DEPTH (DEPTH)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_req_addr   (imem_req_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .halt            (halt),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instr_o         (instr_o),
    .pc_o            (pc_o),
    .misalign        (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  // Reference model: the decoder must see an unbroken +4 PC stream from the last redirect/reset.
  logic [63:0] exp_pc;
  logic [63:0] last_pop_pc;
  bit          halted_m;
  bit          last_acc;
  int unsigned pops;
  int unsigned n_acc;
  logic [63:0] acc_q[$];

  // Memory model state
  bit          pend;
  logic [63:0] pend_addr;
  int unsigned pend_dly;
  bit          rdy_rand;
  bit          rdy_fix;
  bit          lat_rand;
  int unsigned lat_fix;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    logic [31:0] lo;
    lo = a[31:0];
    return {lo[17:2], lo[31:18], 2'b11} ^ 32'h2468_ACE1;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One clock: check pops before the edge, then act as memory at the following negedge.
  task automatic step();
    logic        acc;
    logic [63:0] acc_addr;
    logic        popd;
    logic        redir;
    logic [63:0] rtgt;
    acc      = rst_n && imem_req_valid && imem_req_ready;
    acc_addr = imem_req_addr;
    popd     = rst_n && instr_valid && instr_ready && !(redirect_valid && !halted_m);
    redir    = rst_n && redirect_valid && !halted_m && !halt;
    rtgt     = redirect_pc;
    if (popd) begin
      chk("pop_pc", pc_o, exp_pc);
      chk("pop_instr", {32'h0, instr_o}, {32'h0, mem_word(exp_pc)});
      last_pop_pc = exp_pc;
      exp_pc      = exp_pc + 64'd4;
      pops++;
    end
    if (rst_n && halt) halted_m = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("misalign", {63'h0, misalign}, {63'h0, redir && (rtgt[1:0] != 2'b00)});
    if (redir) exp_pc = {rtgt[63:2], 2'b00};
    imem_resp_valid = 1'b0;
    if (!rst_n) pend = 1'b0;
    last_acc = acc;
    if (acc) begin
      pend      = 1'b1;
      pend_addr = acc_addr;
      pend_dly  = lat_rand ? $urandom_range(0, 2) : lat_fix;
      acc_q.push_back(acc_addr);
      n_acc++;
    end
    if (pend) begin
      if (pend_dly == 0) begin
        imem_resp_valid = 1'b1;
        imem_resp_data  = mem_word(pend_addr);
        pend            = 1'b0;
      end else begin
        pend_dly--;
      end
    end
    imem_req_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_fix;
  endtask

  task automatic wait_acc();
    bit got;
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (last_acc) begin
        got = 1'b1;
        break;
      end
    end
    chk("wait_acc_timeout", {63'h0, got}, 64'h1);
  endtask

  task automatic restart();
    exp_pc   = RST_PC;
    halted_m = 1'b0;
    rst_n    = 1'b1;
  endtask

  initial begin
    int unsigned a;
    int unsigned s;
    int unsigned p;
    logic [63:0] halt_addr;
    bit          got;

    rst_n = 1'b1; imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; halt = 1'b0; instr_ready = 1'b0;
    rdy_rand = 1'b0; rdy_fix = 1'b1; lat_rand = 1'b0; lat_fix = 0;
    pend = 1'b0; pend_addr = '0; pend_dly = 0; pops = 0; n_acc = 0;
    exp_pc = RST_PC; last_pop_pc = '0; halted_m = 1'b0; last_acc = 1'b0;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_req_valid", {63'h0, imem_req_valid}, 64'h0);
    chk("rst_instr_valid", {63'h0, instr_valid}, 64'h0);
    chk("rst_misalign", {63'h0, misalign}, 64'h0);
    chk("rst_instr", {32'h0, instr_o}, 64'h0);
    chk("rst_pc", pc_o, 64'h0);
    chk("rst_state", 64'(dut.state_q), 64'(ST_IDLE));

    // Straight-line fetch, memory ready with next-cycle response
    imem_req_ready = 1'b1; instr_ready = 1'b1;
    restart();
    repeat (14) step();
    for (int i = 0; i < 4; i++) chk("addr_seq", acc_q[i], RST_PC + 64'(4 * i));
    chk("seq_pops", {63'h0, pops >= 4}, 64'h1);

    // Decoder stall fills the buffer and parks the FSM
    instr_ready = 1'b0;
    repeat (8) step();
    a = n_acc;
    repeat (4) step();
    chk("stall_no_acc", 64'(n_acc), 64'(a));
    chk("stall_req_valid", {63'h0, imem_req_valid}, 64'h0);
    chk("stall_instr_valid", {63'h0, instr_valid}, 64'h1);
    chk("stall_count", 64'(dut.u_fifo.count), 64'(DEPTH));
    chk("stall_state", 64'(dut.state_q), 64'(ST_IDLE));
    instr_ready = 1'b1;
    repeat (8) step();
    chk("resume_acc", {63'h0, n_acc > a}, 64'h1);

    // Redirect while a response is outstanding
    lat_fix = 2;
    wait_acc();
    redirect_valid = 1'b1; redirect_pc = 64'h0000_0000_8000_0100;
    step();
    redirect_valid = 1'b0;
    chk("redir_flush", {63'h0, instr_valid}, 64'h0);
    s = acc_q.size(); p = pops;
    repeat (12) step();
    chk("redir_addr", acc_q[s], 64'h0000_0000_8000_0100);
    chk("redir_pops", {63'h0, pops > p}, 64'h1);

    // Misaligned redirect target
    lat_fix = 0;
    repeat (3) step();
    redirect_valid = 1'b1; redirect_pc = 64'h0000_0000_8000_0102;
    step();
    redirect_valid = 1'b0;
    chk("mis_pulse", {63'h0, misalign}, 64'h1);
    s = acc_q.size();
    step();
    chk("mis_clear", {63'h0, misalign}, 64'h0);
    repeat (8) step();
    chk("mis_addr", acc_q[s], 64'h0000_0000_8000_0100);

    // 64-bit PC wrap
    redirect_valid = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFF8;
    step();
    redirect_valid = 1'b0;
    p = pops;
    repeat (12) step();
    chk("wrap_pops", {63'h0, (pops - p) >= 3}, 64'h1);

    // Randomized traffic with random redirects
    rdy_rand = 1'b1; lat_rand = 1'b1;
    p = pops;
    for (int i = 0; i < 400; i++) begin
      instr_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) begin
        redirect_valid = 1'b1;
        redirect_pc    = {32'h0, 32'h8000_0000 | ($urandom & 32'h0000_0FFF)};
      end
      step();
      redirect_valid = 1'b0;
    end
    chk("rand_pops", {63'h0, (pops - p) > 20}, 64'h1);
    rdy_rand = 1'b0; lat_rand = 1'b0; rdy_fix = 1'b1; instr_ready = 1'b1;
    repeat (6) step();

    // Halt while waiting: in-flight word is delivered, then nothing more
    lat_fix = 2;
    wait_acc();
    halt_addr = acc_q[$];
    halt = 1'b1;
    step();
    halt = 1'b0;
    a = n_acc;
    repeat (12) step();
    chk("halt_no_acc", 64'(n_acc), 64'(a));
    chk("halt_req_valid", {63'h0, imem_req_valid}, 64'h0);
    chk("halt_drained", {63'h0, instr_valid}, 64'h0);
    chk("halt_last_pc", last_pop_pc, halt_addr);
    redirect_valid = 1'b1; redirect_pc = 64'h0000_0000_8000_0202;
    step();
    redirect_valid = 1'b0;
    repeat (4) step();
    chk("halt_redir_acc", 64'(n_acc), 64'(a));
    chk("halt_redir_valid", {63'h0, instr_valid}, 64'h0);
    rst_n = 1'b0;
    repeat (2) step();
    restart();
    s = acc_q.size();
    lat_fix = 0;
    repeat (6) step();
    chk("halt_restart_addr", acc_q[s], RST_PC);

    // Asynchronous reset in the middle of a held request
    instr_ready = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (instr_valid) begin
        got = 1'b1;
        break;
      end
      step();
    end
    chk("arst_fill_timeout", {63'h0, got}, 64'h1);
    rdy_fix = 1'b0; imem_req_ready = 1'b0;
    repeat (2) step();
    chk("arst_pre_req", {63'h0, imem_req_valid}, 64'h1);
    chk("arst_pre_valid", {63'h0, instr_valid}, 64'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_req_valid", {63'h0, imem_req_valid}, 64'h0);
    chk("arst_instr_valid", {63'h0, instr_valid}, 64'h0);
    chk("arst_instr", {32'h0, instr_o}, 64'h0);
    chk("arst_pc", pc_o, 64'h0);
    chk("arst_misalign", {63'h0, misalign}, 64'h0);
    @(negedge clk);
    rdy_fix = 1'b1; imem_req_ready = 1'b1; instr_ready = 1'b1;
    restart();
    s = acc_q.size();
    repeat (8) step();
    chk("arst_restart_addr", acc_q[s], RST_PC);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
